mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between the instruction-fetch requester and the load/store requester of the core datapath.
- One transaction is outstanding at a time.
- On conflict, the requester granted last loses (round-robin).
- Supports a variable-latency memory: request/grant on issue, rvalid on read return. The datapath stalls while its request is not yet granted or its read has not returned.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, variable-latency memory between fetch (I) and load/store (D).
// Define MEM_PORT_ARB_PERF_EN to add grant and conflict performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              busy_o
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_cnt_o,
  output logic [31:0]       perf_d_cnt_o,
  output logic [31:0]       perf_conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic              owner;  // 1 = D, 0 = I
  logic              last;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic idle;
  logic sel_i;
  logic sel_d;
  logic conflict;
  logic ret;

  assign idle     = (state == IDLE);
  assign conflict = i_req_i & d_req_i;
  // On conflict the side that did not win last time takes the slot.
  assign sel_d    = d_req_i & (~i_req_i | ~last);
  assign sel_i    = i_req_i & ~sel_d;

  // Grants are combinational on the request inputs, so mask them while reset is held.
  assign i_gnt_o = rst_ni & idle & sel_i;
  assign d_gnt_o = rst_ni & idle & sel_d;

  assign ret        = (state == WAIT) & m_rvalid_i;
  assign i_rvalid_o = ret & ~owner;
  assign d_rvalid_o = ret & owner;
  assign i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;

  assign m_req_o   = (state == REQ);
  assign m_we_o    = m_req_o & lat_we;
  assign m_addr_o  = m_req_o ? lat_addr : '0;
  assign m_wdata_o = m_req_o ? lat_wdata : '0;
  assign busy_o    = ~idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_i || sel_d) begin
            owner     <= sel_d;
            last      <= sel_d;
            lat_we    <= sel_d & d_we_i;
            lat_addr  <= sel_d ? d_addr_i : i_addr_i;
            lat_wdata <= sel_d ? d_wdata_i : '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // Stores finish on acceptance; reads wait for the data beat.
          if (m_gnt_i) state <= lat_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (m_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_i_cnt_o        <= '0;
      perf_d_cnt_o        <= '0;
      perf_conflict_cnt_o <= '0;
    end else if (idle) begin
      if (sel_i)    perf_i_cnt_o        <= perf_i_cnt_o + 32'd1;
      if (sel_d)    perf_d_cnt_o        <= perf_d_cnt_o + 32'd1;
      if (conflict) perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants, memory requests and read data;
// a monitor pops and compares whenever the DUT presents them. Memory is a small reactive model.
module tb_mem_port_arbiter;

  typedef logic [64:0] v_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req_o, m_we_o, busy_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  // Memory inputs come either from the auto responder (a_*) or hand-driven values (h_*).
  logic        auto_mem;
  logic        a_gnt, a_rvalid, h_gnt, h_rvalid;
  logic [31:0] a_rdata, h_rdata;
  int          gnt_delay;
  assign m_gnt    = auto_mem ? a_gnt    : h_gnt;
  assign m_rvalid = auto_mem ? a_rvalid : h_rvalid;
  assign m_rdata  = auto_mem ? a_rdata  : h_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
    .busy_o(busy_o)
`ifdef MEM_PORT_ARB_PERF_EN
    , .perf_i_cnt_o(perf_i), .perf_d_cnt_o(perf_d), .perf_conflict_cnt_o(perf_c)
`endif
  );

  int  total = 0;
  int  bad   = 0;
  bit  gnt_q[$];      // 1 = D grant expected, 0 = I grant expected
  v_t  mreq_q[$];     // {we, addr, wdata}
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  task automatic chk(input string nm, input v_t act, input v_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: expected event did not occur", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, v_t'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                   m_req_o, m_we_o, m_addr_o, m_wdata_o, busy_o}), v_t'(0));
  endtask

  // Returns at posedge+1 right after the grant edge.
  task automatic wait_gnt(input string nm);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        tick();
        return;
      end
    end
    fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy_o) begin
        tick();
        return;
      end
    end
    fail(nm);
    tick();
  endtask

  // Reactive memory: grant after gnt_delay REQ cycles, return DEADBEFF ^ addr one cycle after a read grant.
  logic        r_acc, r_we;
  logic [31:0] r_addr;
  int          r_wcnt;
  initial begin
    a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0; r_wcnt = 0;
    forever begin
      @(negedge clk);
      r_acc  = rst_n && m_req_o && m_gnt;
      r_we   = m_we_o;
      r_addr = m_addr_o;
      @(posedge clk);
      #1;
      a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
      if (!rst_n || !auto_mem) begin
        r_wcnt = 0;
      end else begin
        if (r_acc && !r_we) begin
          a_rvalid = 1'b1;
          a_rdata  = 32'hDEADBEFF ^ r_addr;
        end
        if (m_req_o) begin
          if (r_wcnt >= gnt_delay) begin
            a_gnt  = 1'b1;
            r_wcnt = 0;
          end else begin
            r_wcnt++;
          end
        end
      end
    end
  end

  // Monitor
  logic prev_req;
  v_t   held, cur;
  initial begin
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        continue;
      end
      if (i_gnt || d_gnt) begin
        chk("gnt_onehot", v_t'(i_gnt & d_gnt), v_t'(0));
        if (gnt_q.size() == 0) fail("gnt_unexpected");
        else chk("gnt_who", v_t'(d_gnt), v_t'(gnt_q.pop_front()));
      end
      cur = {m_we_o, m_addr_o, m_wdata_o};
      if (m_req_o) begin
        if (!prev_req) begin
          if (mreq_q.size() == 0) fail("mreq_unexpected");
          else chk("mreq_fields", cur, mreq_q.pop_front());
          held = cur;
        end else begin
          chk("mreq_stable", cur, held);
        end
      end else begin
        chk("mfields_zero_outside_req", cur, v_t'(0));
      end
      prev_req = m_req_o;
      if (i_rvalid) begin
        if (iq.size() == 0) fail("i_rvalid_unexpected");
        else chk("i_rdata", v_t'(i_rdata), v_t'(iq.pop_front()));
      end else chk("i_rdata_zero", v_t'(i_rdata), v_t'(0));
      if (d_rvalid) begin
        if (dq.size() == 0) fail("d_rvalid_unexpected");
        else chk("d_rdata", v_t'(d_rdata), v_t'(dq.pop_front()));
      end else chk("d_rdata_zero", v_t'(d_rdata), v_t'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h4; d_addr = 32'h8; d_wdata = '0;
    auto_mem = 1'b1; gnt_delay = 0;
    h_gnt = 1'b0; h_rvalid = 1'b0; h_rdata = '0;
    #12;
    chk_zero("reset_outputs_zero");
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_reset", v_t'({perf_i, perf_d}), v_t'(0));
`endif
    tick();
    i_req = 1'b0; d_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // Both requesters held from reset: D, I, D, I with data routed to the owner.
    for (int k = 0; k < 2; k++) begin
      gnt_q.push_back(1'b1); mreq_q.push_back({1'b0, 32'h40, 32'h0}); dq.push_back(32'hDEADBEBF);
      gnt_q.push_back(1'b0); mreq_q.push_back({1'b0, 32'h80, 32'h0}); iq.push_back(32'hDEADBE7F);
    end
    d_addr = 32'h40; i_addr = 32'h80; i_req = 1'b1; d_req = 1'b1;
    repeat (4) wait_gnt("conflict_gnt");
    i_req = 1'b0; d_req = 1'b0;
    wait_idle("conflict_idle");

    // Fetch with zero-wait memory, cycle-exact.
    gnt_q.push_back(1'b0); mreq_q.push_back({1'b0, 32'h10, 32'h0}); iq.push_back(32'hDEADBEEF);
    i_addr = 32'h10; i_req = 1'b1;
    @(negedge clk);
    chk("fetch_c0_i_gnt", v_t'(i_gnt), v_t'(1));
    chk("fetch_c0_d_gnt", v_t'(d_gnt), v_t'(0));
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_c1_mreq", v_t'({m_req_o, m_we_o, m_addr_o}), v_t'({1'b1, 1'b0, 32'h10}));
    @(negedge clk);
    chk("fetch_c2_rvalid", v_t'({i_rvalid, i_rdata}), v_t'({1'b1, 32'hDEADBEEF}));
    @(negedge clk);
    chk("fetch_c3_busy", v_t'(busy_o), v_t'(0));
    tick();

    // Store with memory grant delayed 3 cycles; inputs scrambled after grant.
    gnt_delay = 3;
    gnt_q.push_back(1'b1); mreq_q.push_back({1'b1, 32'h20, 32'h12345678});
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_req = 1'b1;
    wait_gnt("store_gnt");
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'hFFFF; d_wdata = 32'hBAD;
    begin
      int n;
      n = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (m_req_o) n++;
        else break;
      end
      chk("store_req_cycles", v_t'(n), v_t'(4));
      chk("store_idle_after_gnt", v_t'(busy_o), v_t'(0));
    end
    tick();
    gnt_delay = 0;

    // Stray memory handshakes while idle.
    auto_mem = 1'b0; h_gnt = 1'b1; h_rvalid = 1'b1; h_rdata = 32'h55;
    repeat (3) begin
      @(negedge clk);
      chk("stray_outputs", v_t'(|{i_gnt, d_gnt, i_rvalid, d_rvalid, m_req_o}), v_t'(0));
      chk("stray_idle", v_t'(busy_o), v_t'(0));
    end
    tick();
    h_gnt = 1'b0; h_rvalid = 1'b0; h_rdata = '0;

    // Reset asserted while waiting for read data; late rvalid must be ignored.
    gnt_q.push_back(1'b0); mreq_q.push_back({1'b0, 32'h50, 32'h0});
    i_addr = 32'h50; i_req = 1'b1;
    @(negedge clk);
    chk("rw_i_gnt", v_t'(i_gnt), v_t'(1));
    tick();
    i_req = 1'b0; h_gnt = 1'b1;
    @(negedge clk);
    chk("rw_mreq", v_t'(m_req_o), v_t'(1));
    tick();
    h_gnt = 1'b0;
    @(negedge clk);
    chk("rw_wait_busy", v_t'({busy_o, i_rvalid}), v_t'({1'b1, 1'b0}));
    tick();
    i_req = 1'b1; d_req = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_in_wait_zero");
    tick();
    i_req = 1'b0; d_req = 1'b0; h_rvalid = 1'b1; h_rdata = 32'h11111111;
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_rvalid_ignored", v_t'({i_rvalid, d_rvalid, busy_o}), v_t'(0));
    tick();
    h_rvalid = 1'b0; h_rdata = '0; auto_mem = 1'b1;

    gnt_q.push_back(1'b0); mreq_q.push_back({1'b0, 32'h60, 32'h0}); iq.push_back(32'hDEADBE9F);
    i_addr = 32'h60; i_req = 1'b1;
    wait_gnt("post_reset_gnt");
    i_req = 1'b0;
    wait_idle("post_reset_idle");

`ifdef MEM_PORT_ARB_PERF_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("perf_after_reset", v_t'({perf_i, perf_d}), v_t'(0));
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) begin
        gnt_q.push_back(1'b1); mreq_q.push_back({1'b0, 32'h40, 32'h0}); dq.push_back(32'hDEADBEBF);
      end else begin
        gnt_q.push_back(1'b0); mreq_q.push_back({1'b0, 32'h80, 32'h0}); iq.push_back(32'hDEADBE7F);
      end
    end
    for (int k = 0; k < 2; k++) begin
      gnt_q.push_back(1'b0); mreq_q.push_back({1'b0, 32'h80, 32'h0}); iq.push_back(32'hDEADBE7F);
    end
    d_addr = 32'h40; i_addr = 32'h80; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    repeat (5) wait_gnt("perf_conflict_gnt");
    d_req = 1'b0;
    repeat (2) wait_gnt("perf_fetch_gnt");
    i_req = 1'b0;
    wait_idle("perf_idle");
    chk("perf_conflict_cnt", v_t'(perf_c), v_t'(5));
    chk("perf_d_cnt", v_t'(perf_d), v_t'(3));
    chk("perf_i_cnt", v_t'(perf_i), v_t'(4));
`endif

    repeat (2) tick();
    chk("queues_drained", v_t'(gnt_q.size() + mreq_q.size() + iq.size() + dq.size()), v_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
